flash_seq: RTL and testbench

//  Command sequencer directly upstream of the ROM controller. Accepts one flash

---
 rtl/flash_seq.sv | 214 +++++++++++++++++++++
 tb/tb_flash_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_seq.sv
// flash_seq: expands one flash command into JEDEC unlock/command byte writes for the
// ROM controller, then polls DQ7/DQ5 until program/erase completion, error or timeout.
module flash_seq #(
  parameter int unsigned ACC_WAIT = 10,
  parameter int unsigned POLL_W   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        done,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        wr_addr,
  output logic        wr_data,
  output logic        rd_data,
  output logic [7:0]  wr_buffer,
  input  logic [7:0]  rd_buffer
);

  localparam int unsigned      WAIT_W    = (ACC_WAIT > 1) ? $clog2(ACC_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACC_WAIT - 1);
  localparam logic [18:0]      UNLK_A    = 19'h00555;
  localparam logic [18:0]      UNLK_B    = 19'h002AA;

  typedef enum logic [2:0] {S_IDLE, S_AL, S_AM, S_AH, S_ST, S_WT} state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_PROG = 2'b01, OP_SERA = 2'b10, OP_CERA = 2'b11} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [18:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        step_q, step_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              reread_q, reread_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              done_q, done_d;

  logic              acc_rd;
  logic [18:0]       acc_addr;
  logic [7:0]        acc_data;
  logic              is_poll;
  logic              poll_expect;

  // Current access selected by op and step; the step past the last write is the poll read.
  always_comb begin
    acc_rd   = 1'b0;
    acc_addr = addr_q;
    acc_data = data_q;
    case (op_q)
      OP_READ: acc_rd = 1'b1;
      OP_PROG: begin
        case (step_q)
          3'd0:    begin acc_addr = UNLK_A; acc_data = 8'hAA; end
          3'd1:    begin acc_addr = UNLK_B; acc_data = 8'h55; end
          3'd2:    begin acc_addr = UNLK_A; acc_data = 8'hA0; end
          3'd3:    ;
          default: acc_rd = 1'b1;
        endcase
      end
      default: begin
        case (step_q)
          3'd0:    begin acc_addr = UNLK_A; acc_data = 8'hAA; end
          3'd1:    begin acc_addr = UNLK_B; acc_data = 8'h55; end
          3'd2:    begin acc_addr = UNLK_A; acc_data = 8'h80; end
          3'd3:    begin acc_addr = UNLK_A; acc_data = 8'hAA; end
          3'd4:    begin acc_addr = UNLK_B; acc_data = 8'h55; end
          3'd5: begin
            if (op_q == OP_CERA) begin
              acc_addr = UNLK_A;
              acc_data = 8'h10;
            end else begin
              acc_data = 8'h30;
            end
          end
          default: acc_rd = 1'b1;
        endcase
      end
    endcase
    is_poll     = acc_rd && (op_q != OP_READ);
    poll_expect = (op_q == OP_PROG) ? data_q[7] : 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    step_d     = step_q;
    wait_d     = wait_q;
    poll_d     = poll_q;
    reread_d   = reread_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          addr_d   = cmd_addr;
          data_d   = cmd_data;
          step_d   = '0;
          poll_d   = '0;
          reread_d = 1'b0;
          state_d  = S_AL;
        end
      end
      S_AL: state_d = S_AM;
      S_AM: state_d = S_AH;
      S_AH: state_d = S_ST;
      S_ST: begin
        wait_d  = '0;
        state_d = S_WT;
      end
      S_WT: begin
        if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + WAIT_W'(1);
        end else if (!acc_rd) begin
          step_d  = step_q + 3'd1;
          state_d = S_AL;
        end else if (!is_poll) begin
          rsp_data_d = rd_buffer;
          rsp_err_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          // A DQ5 hit earns exactly one confirming re-read before reporting failure.
          rsp_data_d = rd_buffer;
          if (rd_buffer[7] == poll_expect) begin
            rsp_err_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else if (reread_q) begin
            rsp_err_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else if (rd_buffer[5]) begin
            reread_d = 1'b1;
            state_d  = S_AL;
          end else if (&poll_q) begin
            rsp_err_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            poll_d  = poll_q + POLL_W'(1);
            state_d = S_AL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      step_q     <= '0;
      wait_q     <= '0;
      poll_q     <= '0;
      reread_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
      poll_q     <= poll_d;
      reread_q   <= reread_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      done_q     <= done_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    wr_addr   = 1'b0;
    wr_data   = 1'b0;
    rd_data   = 1'b0;
    wr_buffer = '0;
    case (state_q)
      S_AL: begin wr_addr = 1'b1; wr_buffer = acc_addr[7:0];  end
      S_AM: begin wr_addr = 1'b1; wr_buffer = acc_addr[15:8]; end
      S_AH: begin wr_addr = 1'b1; wr_buffer = {5'b0, acc_addr[18:16]}; end
      S_ST: begin
        if (acc_rd) begin
          rd_data = 1'b1;
        end else begin
          wr_data   = 1'b1;
          wr_buffer = acc_data;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: ROM models answer reads after 8 edges, a scoreboard
// queue holds expected ROM writes and responses, popped as the DUT produces them.
`timescale 1ns/1ps
module tb_flash_seq;

  localparam int unsigned ACC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_valid4;
  logic [1:0]  cmd_op;
  logic [18:0] cmd_addr;
  logic [7:0]  cmd_data;

  logic        cmd_ready, done, rsp_err, wr_addr, wr_data, rd_data;
  logic [7:0]  rsp_data, wr_buffer, rd_buffer;
  logic        cmd_ready4, done4, rsp_err4, wr_addr4, wr_data4, rd_data4;
  logic [7:0]  rsp_data4, wr_buffer4, rd_buffer4;

  always #5 clk = ~clk;

  flash_seq #(.ACC_WAIT(ACC), .POLL_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(done),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data), .wr_buffer(wr_buffer), .rd_buffer(rd_buffer)
  );

  flash_seq #(.ACC_WAIT(ACC), .POLL_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(done4),
    .rsp_data(rsp_data4), .rsp_err(rsp_err4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .rd_data(rd_data4), .wr_buffer(wr_buffer4), .rd_buffer(rd_buffer4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [26:0] exp_wr_q[$];
  logic [8:0]  exp_rsp_q[$];
  logic [8:0]  exp_rsp4_q[$];

  function automatic logic [31:0] pop_wr();
    if (exp_wr_q.size() == 0) return 32'hFFFF_FFFF;
    return {5'b0, exp_wr_q.pop_front()};
  endfunction

  function automatic logic [31:0] pop_rsp();
    if (exp_rsp_q.size() == 0) return 32'hFFFF_FFFF;
    return {23'b0, exp_rsp_q.pop_front()};
  endfunction

  function automatic logic [31:0] pop_rsp4();
    if (exp_rsp4_q.size() == 0) return 32'hFFFF_FFFF;
    return {23'b0, exp_rsp4_q.pop_front()};
  endfunction

  // ROM model and monitor for the default instance
  logic [7:0]  rom_val = 8'h00, rom_busy_val = 8'h00;
  int          rom_busy_n = 0;
  logic [18:0] exp_rd_addr = '0;
  logic [7:0]  rd_buf_q = 8'h00, rd_pend = 8'h00;
  int          rd_dly = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
  logic [7:0]  ab [3];
  int          ai = 0;
  logic [18:0] cur_addr = '0;
  logic        ready_prev = 1'b1;

  assign rd_buffer = rd_buf_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      ai <= 0;
    end else begin
      ready_prev <= cmd_ready;
      if (ready_prev && !cmd_ready) acc_cnt <= acc_cnt + 1;
      if (wr_addr || wr_data || rd_data)
        check("strobe_onehot", 32'($onehot({wr_addr, wr_data, rd_data})), 32'd1);
      if (wr_addr) begin
        ab[ai] <= wr_buffer;
        if (ai == 2) begin
          cur_addr <= {wr_buffer[2:0], ab[1], ab[0]};
          check("ah_pad", 32'(wr_buffer[7:3]), 32'd0);
          ai <= 0;
        end else begin
          ai <= ai + 1;
        end
      end
      if (wr_data) begin
        check("rom_write", {5'b0, cur_addr, wr_buffer}, pop_wr());
        wr_cnt <= wr_cnt + 1;
      end
      if (rd_data) begin
        check("rd_addr", 32'(cur_addr), 32'(exp_rd_addr));
        rd_pend  <= (rd_cnt < rom_busy_n) ? rom_busy_val : rom_val;
        rd_buf_q <= 8'hEE;
        rd_dly   <= 8;
        rd_cnt   <= rd_cnt + 1;
      end else if (rd_dly > 0) begin
        rd_dly <= rd_dly - 1;
        if (rd_dly == 1) rd_buf_q <= rd_pend;
      end
      if (done) begin
        check("rsp", {23'b0, rsp_err, rsp_data}, pop_rsp());
        done_cnt <= done_cnt + 1;
      end
    end
  end

  // ROM model and monitor for the narrow poll-counter instance
  logic [7:0] rom4_val = 8'h00;
  logic [7:0] rd4_buf = 8'h00;
  int         rd4_dly = 0, rd4_cnt = 0;

  assign rd_buffer4 = rd4_buf;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_addr4 || wr_data4 || rd_data4)
        check("strobe_onehot4", 32'($onehot({wr_addr4, wr_data4, rd_data4})), 32'd1);
      if (rd_data4) begin
        rd4_buf <= 8'hEE;
        rd4_dly <= 8;
        rd4_cnt <= rd4_cnt + 1;
      end else if (rd4_dly > 0) begin
        rd4_dly <= rd4_dly - 1;
        if (rd4_dly == 1) rd4_buf <= rom4_val;
      end
      if (done4) check("rsp4", {23'b0, rsp_err4, rsp_data4}, pop_rsp4());
    end
  end

  task automatic issue(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d,
                       input bit four, input bit hold);
    @(negedge clk);
    check("ready_before", four ? cmd_ready4 : cmd_ready, 1);
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    if (four) cmd_valid4 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      cmd_valid  = 1'b0;
      cmd_valid4 = 1'b0;
    end
    cmd_op   = ~op;
    cmd_addr = ~a;
    cmd_data = ~d;
  endtask

  // Cycles counted from the accept edge to the done cycle; -1 if the budget runs out.
  task automatic wait_done(input bit four, input int budget, output int cycles, output int busy_rdy);
    int n;
    n = 0;
    cycles = -1;
    busy_rdy = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (four ? done4 : done) begin
        cycles = n;
        cmd_valid  = 1'b0;
        cmd_valid4 = 1'b0;
        break;
      end
      if (four ? cmd_ready4 : cmd_ready) busy_rdy++;
    end
    check("done_seen", 32'(cycles > 0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, br, n, d0, a0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_valid4 = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_strobes", {wr_addr, wr_data, rd_data}, 0);
    check("rst_wr_buffer", wr_buffer, 0);
    check("rst_ready4", cmd_ready4, 1);
    check("rst_wr_buffer4", wr_buffer4, 0);
    #2 rst_n = 1'b1;

    // 1: plain read
    rom_busy_n = 0; rom_val = 8'h5A; rd_cnt = 0; exp_rd_addr = 19'h71234;
    exp_rsp_q.push_back({1'b0, 8'h5A});
    issue(2'b00, 19'h71234, 8'h00, 0, 0);
    wait_done(0, 100, cyc, br);
    check("t1_latency", cyc, 4 + ACC + 1);
    check("t1_reads", rd_cnt, 1);
    @(negedge clk);
    check("t1_rsp_held", {done, rsp_err, rsp_data}, {1'b0, 1'b0, 8'h5A});

    // 2: program, DQ7 inverted for three polls
    rom_busy_n = 3; rom_busy_val = 8'h80; rom_val = 8'h3C; rd_cnt = 0; wr_cnt = 0;
    exp_rd_addr = 19'h000FF;
    exp_wr_q.push_back({19'h00555, 8'hAA});
    exp_wr_q.push_back({19'h002AA, 8'h55});
    exp_wr_q.push_back({19'h00555, 8'hA0});
    exp_wr_q.push_back({19'h000FF, 8'h3C});
    exp_rsp_q.push_back({1'b0, 8'h3C});
    issue(2'b01, 19'h000FF, 8'h3C, 0, 0);
    wait_done(0, 400, cyc, br);
    check("t2_latency", cyc, 8 * (4 + ACC) + 1);
    check("t2_writes", wr_cnt, 4);
    check("t2_reads", rd_cnt, 4);

    // 3: sector erase, DQ5 stuck -> single re-read then error
    rom_busy_n = 0; rom_val = 8'h20; rd_cnt = 0; wr_cnt = 0; exp_rd_addr = 19'h10000;
    exp_wr_q.push_back({19'h00555, 8'hAA});
    exp_wr_q.push_back({19'h002AA, 8'h55});
    exp_wr_q.push_back({19'h00555, 8'h80});
    exp_wr_q.push_back({19'h00555, 8'hAA});
    exp_wr_q.push_back({19'h002AA, 8'h55});
    exp_wr_q.push_back({19'h10000, 8'h30});
    exp_rsp_q.push_back({1'b1, 8'h20});
    issue(2'b10, 19'h10000, 8'h00, 0, 0);
    wait_done(0, 400, cyc, br);
    check("t3_latency", cyc, 8 * (4 + ACC) + 1);
    check("t3_writes", wr_cnt, 6);
    check("t3_reads", rd_cnt, 2);

    // 4: POLL_W=4 program that never completes -> timeout after 16 reads
    rom4_val = 8'h00; rd4_cnt = 0;
    exp_rsp4_q.push_back({1'b1, 8'h00});
    issue(2'b01, 19'h30ABC, 8'h80, 1, 0);
    wait_done(1, 600, cyc, br);
    check("t4_latency", cyc, 20 * (4 + ACC) + 1);
    check("t4_reads", rd4_cnt, 16);

    // 5: chip erase with cmd_valid held throughout
    rom_busy_n = 0; rom_val = 8'h80; rd_cnt = 0; wr_cnt = 0; exp_rd_addr = 19'h55AA5;
    exp_wr_q.push_back({19'h00555, 8'hAA});
    exp_wr_q.push_back({19'h002AA, 8'h55});
    exp_wr_q.push_back({19'h00555, 8'h80});
    exp_wr_q.push_back({19'h00555, 8'hAA});
    exp_wr_q.push_back({19'h002AA, 8'h55});
    exp_wr_q.push_back({19'h00555, 8'h10});
    exp_rsp_q.push_back({1'b0, 8'h80});
    a0 = acc_cnt;
    issue(2'b11, 19'h55AA5, 8'h00, 0, 1);
    wait_done(0, 400, cyc, br);
    check("t5_latency", cyc, 7 * (4 + ACC) + 1);
    check("t5_busy_ready", br, 0);
    check("t5_writes", wr_cnt, 6);
    check("t5_reads", rd_cnt, 1);
    @(negedge clk);
    check("t5_ready_after", cmd_ready, 1);
    check("t5_accepts", acc_cnt - a0, 1);

    // 6: reset during the wait after the second write
    wr_cnt = 0; d0 = done_cnt;
    exp_wr_q.push_back({19'h00555, 8'hAA});
    exp_wr_q.push_back({19'h002AA, 8'h55});
    issue(2'b10, 19'h20000, 8'h00, 0, 0);
    n = 0;
    while (wr_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_wr2", wr_cnt, 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_strobes", {wr_addr, wr_data, rd_data}, 0);
    check("t6_rst_ready", cmd_ready, 1);
    check("t6_rst_done", done, 0);
    check("t6_rst_wr_buffer", wr_buffer, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    exp_wr_q.delete();
    repeat (2) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    rom_busy_n = 0; rom_val = 8'hC3; rd_cnt = 0; exp_rd_addr = 19'h00042;
    exp_rsp_q.push_back({1'b0, 8'hC3});
    issue(2'b00, 19'h00042, 8'h00, 0, 0);
    wait_done(0, 100, cyc, br);
    check("t6_read_latency", cyc, 4 + ACC + 1);
    check("t6_read_count", rd_cnt, 1);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_wr_q.size() + exp_rsp_q.size() + exp_rsp4_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
